// File: rtl/eth_ocm_buffer_mem.sv
// ---------------------------------------------------------------------------
// eth_ocm_buffer_mem
//
// Packet-buffer RAM shared between the Ethernet MAC DMA master (mem_* port)
// and the host CPU (host_* port). Both are Avalon-MM slave ports backed by a
// single-port RAM of DEPTH_WORDS 32-bit words. A round-robin arbiter and a
// small access FSM serialise the two ports: a granted access waits
// WAIT_STATES cycles, commits in one cycle, then acknowledges in one cycle.
//
// Ports
//   clk, reset_n            single clock, asynchronous active-low reset
//   mem_address[31:0]       MAC byte address (bits [1:0] ignored)
//   mem_write / mem_read    MAC requests, held until completion
//   mem_writedata[31:0]     MAC write data
//   mem_byteenable[3:0]     MAC byte lanes
//   mem_readdata[31:0]      MAC read data, valid in the completion cycle
//   mem_waitrequest_n       one-cycle completion pulse for the MAC
//   host_address[W-1:0]     host word index
//   host_write / host_read  host requests, held until completion
//   host_writedata[31:0]    host write data
//   host_byteenable[3:0]    host byte lanes
//   host_readdata[31:0]     host read data, valid in the completion cycle
//   host_waitrequest_n      one-cycle completion pulse for the host
//   oor_count[7:0]          saturating count of out-of-range MAC accesses
//   fsm_state[1:0]          access FSM state (0 IDLE, 1 WAIT, 2 COMMIT, 3 ACK)
//   fsm_grant               port currently granted (0 MAC, 1 host)
//
// Handshake: a master raises write or read (write wins if both) and holds the
// request, address and data stable until it sees its waitrequest_n high for
// exactly one cycle; that cycle completes the access and read data is valid
// in it. Dropping the request before the commit cycle cancels the access
// with no side effects and no completion pulse.
// ---------------------------------------------------------------------------
module eth_ocm_buffer_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF,
  localparam int         W           = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  // MAC DMA port
  input  logic [31:0]   mem_address,
  input  logic          mem_write,
  input  logic [31:0]   mem_writedata,
  input  logic [3:0]    mem_byteenable,
  input  logic          mem_read,
  output logic [31:0]   mem_readdata,
  output logic          mem_waitrequest_n,
  // host port
  input  logic [W-1:0]  host_address,
  input  logic          host_write,
  input  logic          host_read,
  input  logic [31:0]   host_writedata,
  input  logic [3:0]    host_byteenable,
  output logic [31:0]   host_readdata,
  output logic          host_waitrequest_n,
  // status and debug
  output logic [7:0]    oor_count,
  output logic [1:0]    fsm_state,
  output logic          fsm_grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic GNT_MAC  = 1'b0;
  localparam logic GNT_HOST = 1'b1;

  // Byte span of the buffer in the MAC address space.
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  // The wait counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles; with no wait states the FSM goes straight to COMMIT.
  localparam logic [3:0] CNT_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     FIRST_STATE = (WAIT_STATES > 0) ? S_WAIT : S_COMMIT;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic          mem_req;
  logic          host_req;
  logic [31:0]   mem_offset;
  logic          mem_in_range;
  logic [W-1:0]  mem_index;

  assign mem_req  = mem_write | mem_read;
  assign host_req = host_write | host_read;

  // Wrap-around subtraction: addresses below ADDR_BASE produce a huge offset
  // and therefore fall out of range naturally.
  assign mem_offset   = mem_address - ADDR_BASE;
  assign mem_in_range = (mem_offset < SPAN);
  assign mem_index    = mem_offset[W+1:2];

  // -------------------------------------------------------------------------
  // FSM registers
  // -------------------------------------------------------------------------
  state_t       state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic         grant, grant_n;
  logic         last_grant, last_grant_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      grant      <= GNT_MAC;
      last_grant <= GNT_HOST;   // MAC wins the first tie after reset
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
    end
  end

  // -------------------------------------------------------------------------
  // Granted-port view: everything downstream of the arbiter looks only at
  // these signals, so the FSM and datapath are port-agnostic.
  // -------------------------------------------------------------------------
  logic          gnt_req;
  logic          gnt_write;
  logic [W-1:0]  gnt_index;
  logic          gnt_in_range;
  logic [31:0]   gnt_wdata;
  logic [3:0]    gnt_be;

  always_comb begin
    if (grant == GNT_HOST) begin
      gnt_req      = host_req;
      gnt_write    = host_write;
      gnt_index    = host_address;
      gnt_in_range = 1'b1;
      gnt_wdata    = host_writedata;
      gnt_be       = host_byteenable;
    end else begin
      gnt_req      = mem_req;
      gnt_write    = mem_write;
      gnt_index    = mem_index;
      gnt_in_range = mem_in_range;
      gnt_wdata    = mem_writedata;
      gnt_be       = mem_byteenable;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    grant_n      = grant;
    last_grant_n = last_grant;

    case (state)
      S_IDLE: begin
        if (mem_req && host_req) begin
          // Tie: the port that did not win the previous tie goes first.
          grant_n      = ~last_grant;
          last_grant_n = ~last_grant;
          state_n      = FIRST_STATE;
          cnt_n        = CNT_INIT;
        end else if (mem_req) begin
          grant_n = GNT_MAC;
          state_n = FIRST_STATE;
          cnt_n   = CNT_INIT;
        end else if (host_req) begin
          grant_n = GNT_HOST;
          state_n = FIRST_STATE;
          cnt_n   = CNT_INIT;
        end
      end

      S_WAIT: begin
        if (!gnt_req) begin
          state_n = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_n = S_COMMIT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end

      S_COMMIT: begin
        state_n = gnt_req ? S_ACK : S_IDLE;
      end

      S_ACK: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // The access takes effect only if the granted port still requests in the
  // COMMIT cycle; a dropped request there is an abort like one in WAIT.
  logic commit_fire;
  assign commit_fire = (state == S_COMMIT) && gnt_req;

  // -------------------------------------------------------------------------
  // Shared RAM (contents not reset)
  // -------------------------------------------------------------------------
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_rdata;

  assign ram_rdata = ram[gnt_index];

  always_ff @(posedge clk) begin
    if (commit_fire && gnt_write && gnt_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (gnt_be[i]) begin
          ram[gnt_index][8*i +: 8] <= gnt_wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read data and out-of-range counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_readdata  <= 32'd0;
      host_readdata <= 32'd0;
      oor_count     <= 8'd0;
    end else if (commit_fire) begin
      if (!gnt_write) begin
        if (grant == GNT_HOST) begin
          host_readdata <= ram_rdata;
        end else begin
          mem_readdata <= gnt_in_range ? ram_rdata : OOR_DATA;
        end
      end
      if ((grant == GNT_MAC) && !mem_in_range && (oor_count != 8'hFF)) begin
        oor_count <= oor_count + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Completion pulses and debug view
  // -------------------------------------------------------------------------
  assign mem_waitrequest_n  = (state == S_ACK) && (grant == GNT_MAC);
  assign host_waitrequest_n = (state == S_ACK) && (grant == GNT_HOST);

  assign fsm_state = state;
  assign fsm_grant = grant;

endmodule
